// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM encoding, parity and frame constants for uart_tx
package uart_tx_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and serial line bundle between a producer and uart_tx
interface uart_tx_if;

    logic [7:0] p_data;
    logic       par_en;
    logic       par_typ;
    logic       data_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;

    modport master (
        output p_data, par_en, par_typ, data_valid,
        input  tx_ready, tx_out, busy
    );

    modport slave (
        input  p_data, par_en, par_typ, data_valid,
        output tx_ready, tx_out, busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-time counter producing a tick on the last cycle of each bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done,
    output logic next_done
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= 16'd0;
        end else if (bit_done) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    assign bit_done = (cnt == LAST);

    // Lets the owner register a signal that is high exactly in the final cycle of a bit.
    assign next_done = (LAST == 16'd0) ||
                       (!clear && !bit_done && (cnt == LAST - 16'd1));

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8E1/8O1 UART transmitter with back-to-back frame support
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    logic [2:0]           state, state_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] data_r;
    logic                 par_en_r, par_typ_r;
    logic                 tx_r, tx_n;
    logic                 busy_r;
    logic                 ready_r, ready_n;
    logic                 bit_done, next_done;
    logic                 accept;
    logic                 parity_bit;

    assign accept     = bus.data_valid && ready_r;
    assign parity_bit = (^data_r) ^ (par_typ_r != PAR_EVEN);

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == S_IDLE),
        .bit_done  (bit_done),
        .next_done (next_done)
    );

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        tx_n      = tx_r;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_START;
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_n   = S_DATA;
                    bit_idx_n = 3'd0;
                    tx_n      = data_r[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_n = par_en_r ? S_PARITY : S_STOP;
                        tx_n    = par_en_r ? parity_bit : 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = data_r[bit_idx + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                // tx_ready is only high on the last stop cycle, so accept implies bit_done here.
                if (bit_done) begin
                    state_n = accept ? S_START : S_IDLE;
                    tx_n    = !accept;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
        ready_n = (state_n == S_IDLE) || ((state_n == S_STOP) && next_done);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            bit_idx   <= 3'd0;
            data_r    <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            tx_r    <= tx_n;
            busy_r  <= (state_n != S_IDLE);
            ready_r <= ready_n;
            if (accept) begin
                data_r    <= bus.p_data;
                par_en_r  <= bus.par_en;
                par_typ_r <= bus.par_typ;
            end
        end
    end

    assign bus.tx_out   = tx_r;
    assign bus.busy     = busy_r;
    assign bus.tx_ready = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx at CLKS_PER_BIT 1 and 4
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    uart_tx_if if1 ();
    uart_tx_if if4 ();

    uart_tx #(.CLKS_PER_BIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Drive-only: present a byte to the CLKS_PER_BIT=1 DUT; returns at the negedge of start-bit cycle 0.
    task automatic start1(input logic [7:0] d, input logic pe, input logic pt);
        if1.p_data     = d;
        if1.par_en     = pe;
        if1.par_typ    = pt;
        if1.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if1.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if1.data_valid = 1'b1;
        if1.p_data     = 8'hFF;
        if4.data_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (if1.tx_out !== 1'b1)   $display("FAIL reset_tx1 got %b exp 1", if1.tx_out);   else n_pass++;
        n_total++; if (if1.busy !== 1'b0)     $display("FAIL reset_busy1 got %b exp 0", if1.busy);   else n_pass++;
        n_total++; if (if1.tx_ready !== 1'b1) $display("FAIL reset_rdy1 got %b exp 1", if1.tx_ready); else n_pass++;
        n_total++; if (if4.tx_out !== 1'b1)   $display("FAIL reset_tx4 got %b exp 1", if4.tx_out);   else n_pass++;
        n_total++; if (if4.busy !== 1'b0)     $display("FAIL reset_busy4 got %b exp 0", if4.busy);   else n_pass++;
        n_total++; if (if4.tx_ready !== 1'b1) $display("FAIL reset_rdy4 got %b exp 1", if4.tx_ready); else n_pass++;
        rst = 1'b1;
        if1.data_valid = 1'b0;
        if4.data_valid = 1'b0;
        @(negedge clk);
        n_total++; if (if1.busy !== 1'b0) $display("FAIL reset_dv_ignored1 got %b exp 0", if1.busy); else n_pass++;
        n_total++; if (if4.busy !== 1'b0) $display("FAIL reset_dv_ignored4 got %b exp 0", if4.busy); else n_pass++;
    endtask

    task automatic test_frames_cpb1();
        logic [7:0]  dat [3] = '{8'hA5, 8'hA5, 8'h3C};
        logic        pe  [3] = '{1'b1, 1'b1, 1'b0};
        logic        pt  [3] = '{1'b0, 1'b1, 1'b0};
        int          len [3] = '{11, 11, 10};
        logic [0:10] exp [3] = '{11'b01010010101, 11'b01010010111, 11'b00011110010};
        logic        er;
        for (int v = 0; v < 3; v++) begin
            start1(dat[v], pe[v], pt[v]);
            for (int c = 0; c < len[v]; c++) begin
                er = (c == len[v] - 1);
                n_total++; if (if1.tx_out !== exp[v][c]) $display("FAIL frame%0d_tx c=%0d got %b exp %b", v, c, if1.tx_out, exp[v][c]); else n_pass++;
                n_total++; if (if1.busy !== 1'b1)        $display("FAIL frame%0d_busy c=%0d got %b exp 1", v, c, if1.busy); else n_pass++;
                n_total++; if (if1.tx_ready !== er)      $display("FAIL frame%0d_rdy c=%0d got %b exp %b", v, c, if1.tx_ready, er); else n_pass++;
                @(negedge clk);
            end
            n_total++; if (if1.tx_out !== 1'b1)   $display("FAIL frame%0d_idle_tx got %b exp 1", v, if1.tx_out); else n_pass++;
            n_total++; if (if1.busy !== 1'b0)     $display("FAIL frame%0d_idle_busy got %b exp 0", v, if1.busy); else n_pass++;
            n_total++; if (if1.tx_ready !== 1'b1) $display("FAIL frame%0d_idle_rdy got %b exp 1", v, if1.tx_ready); else n_pass++;
        end
    endtask

    task automatic test_cpb4();
        logic [0:9] f = 10'b0100000001;
        logic       er;
        if4.p_data     = 8'h01;
        if4.par_en     = 1'b0;
        if4.par_typ    = 1'b0;
        if4.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.data_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            er = (c == 39);
            n_total++; if (if4.tx_out !== f[c/4]) $display("FAIL cpb4_tx c=%0d got %b exp %b", c, if4.tx_out, f[c/4]); else n_pass++;
            n_total++; if (if4.busy !== 1'b1)     $display("FAIL cpb4_busy c=%0d got %b exp 1", c, if4.busy); else n_pass++;
            n_total++; if (if4.tx_ready !== er)   $display("FAIL cpb4_rdy c=%0d got %b exp %b", c, if4.tx_ready, er); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (if4.busy !== 1'b0)     $display("FAIL cpb4_idle_busy got %b exp 0", if4.busy); else n_pass++;
        n_total++; if (if4.tx_ready !== 1'b1) $display("FAIL cpb4_idle_rdy got %b exp 1", if4.tx_ready); else n_pass++;
        n_total++; if (if4.tx_out !== 1'b1)   $display("FAIL cpb4_idle_tx got %b exp 1", if4.tx_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [0:19] exp = 20'b01010101010010101011;
        logic        er;
        if1.p_data     = 8'h55;
        if1.par_en     = 1'b0;
        if1.par_typ    = 1'b0;
        if1.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            er = (c == 9) || (c == 19);
            n_total++; if (if1.tx_out !== exp[c]) $display("FAIL b2b_tx c=%0d got %b exp %b", c, if1.tx_out, exp[c]); else n_pass++;
            n_total++; if (if1.busy !== 1'b1)     $display("FAIL b2b_busy c=%0d got %b exp 1", c, if1.busy); else n_pass++;
            n_total++; if (if1.tx_ready !== er)   $display("FAIL b2b_rdy c=%0d got %b exp %b", c, if1.tx_ready, er); else n_pass++;
            if (c == 0)  if1.p_data = 8'hAA;
            if (c == 10) if1.data_valid = 1'b0;
            @(negedge clk);
        end
        n_total++; if (if1.busy !== 1'b0) $display("FAIL b2b_idle_busy got %b exp 0", if1.busy); else n_pass++;
    endtask

    task automatic test_midframe_ignore();
        logic [0:9] exp = 10'b0001111001;
        start1(8'h3C, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            n_total++; if (if1.tx_out !== exp[c]) $display("FAIL ignore_tx c=%0d got %b exp %b", c, if1.tx_out, exp[c]); else n_pass++;
            if (c == 3) begin
                if1.data_valid = 1'b1;
                if1.p_data     = 8'h00;
                if1.par_en     = 1'b1;
                if1.par_typ    = 1'b1;
            end
            if (c == 4) if1.data_valid = 1'b0;
            @(negedge clk);
        end
        n_total++; if (if1.busy !== 1'b0)   $display("FAIL ignore_idle_busy got %b exp 0", if1.busy); else n_pass++;
        n_total++; if (if1.tx_out !== 1'b1) $display("FAIL ignore_idle_tx got %b exp 1", if1.tx_out); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [0:10] exp = 11'b01000000101;
        logic        er;
        start1(8'hFF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_total++; if (if1.busy !== 1'b1) $display("FAIL rstmid_busy_before got %b exp 1", if1.busy); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (if1.tx_out !== 1'b1)   $display("FAIL rstmid_tx got %b exp 1", if1.tx_out); else n_pass++;
        n_total++; if (if1.busy !== 1'b0)     $display("FAIL rstmid_busy got %b exp 0", if1.busy); else n_pass++;
        n_total++; if (if1.tx_ready !== 1'b1) $display("FAIL rstmid_rdy got %b exp 1", if1.tx_ready); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (if1.busy !== 1'b0)   $display("FAIL rstmid_noresume_busy got %b exp 0", if1.busy); else n_pass++;
        n_total++; if (if1.tx_out !== 1'b1) $display("FAIL rstmid_noresume_tx got %b exp 1", if1.tx_out); else n_pass++;
        start1(8'h81, 1'b1, 1'b0);
        for (int c = 0; c < 11; c++) begin
            er = (c == 10);
            n_total++; if (if1.tx_out !== exp[c]) $display("FAIL rstmid_frame_tx c=%0d got %b exp %b", c, if1.tx_out, exp[c]); else n_pass++;
            n_total++; if (if1.tx_ready !== er)   $display("FAIL rstmid_frame_rdy c=%0d got %b exp %b", c, if1.tx_ready, er); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (if1.busy !== 1'b0) $display("FAIL rstmid_frame_idle got %b exp 0", if1.busy); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [7:0] rx;
        logic       pe, pt, pbit, par_err, stop_err;
        int         w;
        for (int mode = 0; mode < 3; mode++) begin
            pe = (mode != 0);
            pt = (mode == 2);
            for (int b = 0; b < 256; b++) begin
                start1(8'(b), pe, pt);
                w = 0;
                while (if1.tx_out !== 1'b0 && w < 4) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    rx[i] = if1.tx_out;
                end
                par_err = 1'b0;
                if (pe) begin
                    @(negedge clk);
                    pbit    = if1.tx_out;
                    par_err = (pbit !== ((^rx) ^ pt));
                end
                @(negedge clk);
                stop_err = (if1.tx_out !== 1'b1);
                n_total++;
                if (rx !== 8'(b) || par_err || stop_err || w >= 4)
                    $display("FAIL loopback mode=%0d byte=%02h got %02h par_error=%b stop_error=%b start_wait=%0d exp %02h/0/0",
                             mode, b, rx, par_err, stop_err, w, 8'(b));
                else
                    n_pass++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        if1.p_data     = 8'h00;
        if1.par_en     = 1'b0;
        if1.par_typ    = 1'b0;
        if1.data_valid = 1'b0;
        if4.p_data     = 8'h00;
        if4.par_en     = 1'b0;
        if4.par_typ    = 1'b0;
        if4.data_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_frames_cpb1();
        test_cpb4();
        test_back_to_back();
        test_midframe_ignore();
        test_reset_midframe();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
